// File: rtl/lis3dh_pkg.sv
// Shared constants for the LIS3DH polling sequencer: register map, command bits,
// and the sequencer state encoding.
package lis3dh_pkg;

    localparam logic [7:0]  REG_WHO_AM_I = 8'h0F;
    localparam logic [7:0]  REG_CTRL1    = 8'h20;
    localparam logic [7:0]  REG_OUT_X_L  = 8'h28;
    localparam logic [7:0]  RD_BIT       = 8'h80;
    localparam logic [7:0]  AUTOINC_BIT  = 8'h40;
    localparam logic [7:0]  WHOAMI_VAL   = 8'h33;
    localparam logic [15:0] DIVCFG_CMD   = 16'h8080;

    typedef enum logic [3:0] {
        ST_IDLE_OFF,
        ST_DIVCFG,
        ST_WHOAMI,
        ST_CHK_ID,
        ST_WR_CTRL1,
        ST_WAIT_PERIOD,
        ST_RD_X,
        ST_RD_Y,
        ST_RD_Z,
        ST_PUBLISH,
        ST_IDLE_HOLD,
        ST_ERROR
    } state_e;

    // axis 0/1/2 -> burst read of OUT_X_L/OUT_Y_L/OUT_Z_L (0xE8/0xEA/0xEC)
    function automatic logic [7:0] axis_rd_cmd(input logic [1:0] axis);
        return RD_BIT | AUTOINC_BIT | (REG_OUT_X_L + {5'd0, axis, 1'b0});
    endfunction

endpackage

// File: rtl/lis3dh_poll_ctrl_if.sv
// Request/ready bus between the polling sequencer (master) and spi_master (slave).
interface lis3dh_poll_ctrl_if;
    logic [4:0]  spi_nbits;
    logic [31:0] spi_mosi_data;
    logic [31:0] spi_miso_data;
    logic        spi_request;
    logic        spi_ready;
    logic        spi_master_nrst;

    modport master (
        output spi_nbits, spi_mosi_data, spi_request, spi_master_nrst,
        input  spi_miso_data, spi_ready
    );
    modport slave (
        input  spi_nbits, spi_mosi_data, spi_request, spi_master_nrst,
        output spi_miso_data, spi_ready
    );
endinterface

// File: rtl/spi_xfer_hs.sv
// One spi_master transfer handshake: request pulse, ready fall/rise tracking,
// timeout, and capture of the low 16 miso bits on the completing cycle.
module spi_xfer_hs #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_in,
    input  logic        nrst,
    input  logic        start,
    input  logic        pulse_only,
    input  logic        ready,
    input  logic [15:0] miso,
    output logic        req,
    output logic        done,
    output logic        timeout,
    output logic [15:0] rdata
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic          req_q, req_d, act_q, act_d, low_q, low_d;
    logic          done_q, done_d, to_q, to_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   rdata_q, rdata_d;

    // cnt_q equals the cycle index relative to the request cycle; timeout_q
    // rises one cycle early so the registered err lands TIMEOUT_CYCLES after it.
    always_comb begin
        req_d   = start;
        act_d   = act_q;
        low_d   = low_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        to_d    = 1'b0;
        rdata_d = rdata_q;
        if (start) begin
            act_d = !pulse_only;
            low_d = 1'b0;
            cnt_d = '0;
        end else if (act_q) begin
            cnt_d = cnt_q + 1'b1;
            if (!req_q) begin
                if (low_q && ready) begin
                    act_d   = 1'b0;
                    done_d  = 1'b1;
                    rdata_d = miso;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 2)) begin
                    act_d = 1'b0;
                    to_d  = 1'b1;
                end else if (!ready) begin
                    low_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!nrst) begin
            req_q   <= 1'b0;
            act_q   <= 1'b0;
            low_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            req_q   <= req_d;
            act_q   <= act_d;
            low_q   <= low_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            to_q    <= to_d;
            rdata_q <= rdata_d;
        end
    end

    assign req     = req_q;
    assign done    = done_q;
    assign timeout = to_q;
    assign rdata   = rdata_q;
endmodule

// File: rtl/lis3dh_poll_ctrl.sv
// LIS3DH bring-up (WHO_AM_I check, CTRL_REG1 write) and periodic X/Y/Z polling.
// Define SPI_DIVCFG_EN to program the spi_master divider before WHO_AM_I.
module lis3dh_poll_ctrl
    import lis3dh_pkg::*;
#(
    parameter int          PERIOD_CYCLES  = 1000,
    parameter logic [7:0]  CTRL1_VAL      = 8'h57,
    parameter logic [15:0] DIV_COEF       = 16'd0,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic                clk_in,
    input  logic                nrst,
    input  logic                enable,
    lis3dh_poll_ctrl_if.master  spi,
    output logic [15:0]         acc_x,
    output logic [15:0]         acc_y,
    output logic [15:0]         acc_z,
    output logic                sample_valid,
    output logic                id_ok,
    output logic                err,
    output logic                busy
);
    localparam int            PW         = $clog2(PERIOD_CYCLES);
    localparam logic [PW-1:0] PER_LAST   = PW'(PERIOD_CYCLES - 1);
    localparam logic [31:0]   WHOAMI_CMD = {16'h0, RD_BIT | REG_WHO_AM_I, 8'h00};

    state_e        state_q, state_d;
    logic [4:0]    nbits_q, nbits_d;
    logic [31:0]   mosi_q, mosi_d;
    logic [15:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d, acc_z_q, acc_z_d;
    logic [15:0]   shx_q, shx_d, shy_q, shy_d;
    logic          valid_q, valid_d, id_ok_q, id_ok_d, err_q, err_d, busy_q, busy_d;
    logic [PW-1:0] per_q, per_d;
    logic          start, pulse_only, begin_set;
    logic          hs_done, hs_timeout;
    logic [15:0]   hs_rdata, axis_val;
`ifdef SPI_DIVCFG_EN
    logic          mnrst_q, mnrst_d;
    logic [1:0]    phase_q, phase_d;
`endif

    spi_xfer_hs #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_hs (
        .clk_in     (clk_in),
        .nrst       (nrst),
        .start      (start),
        .pulse_only (pulse_only),
        .ready      (spi.spi_ready),
        .miso       (spi.spi_miso_data[15:0]),
        .req        (spi.spi_request),
        .done       (hs_done),
        .timeout    (hs_timeout),
        .rdata      (hs_rdata)
    );

    // burst read returns L then H; H lands in the last byte shifted in
    assign axis_val = {hs_rdata[7:0], hs_rdata[15:8]};

    always_comb begin
        state_d   = state_q;
        nbits_d   = nbits_q;
        mosi_d    = mosi_q;
        acc_x_d   = acc_x_q;
        acc_y_d   = acc_y_q;
        acc_z_d   = acc_z_q;
        shx_d     = shx_q;
        shy_d     = shy_q;
        id_ok_d   = id_ok_q;
        err_d     = err_q;
        per_d     = (per_q == PER_LAST) ? per_q : per_q + 1'b1;
        start     = 1'b0;
        pulse_only = 1'b0;
        begin_set = 1'b0;
`ifdef SPI_DIVCFG_EN
        mnrst_d   = mnrst_q;
        phase_d   = phase_q;
`endif
        if (hs_timeout) begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
        end else begin
            case (state_q)
                ST_IDLE_OFF: if (enable) begin
`ifdef SPI_DIVCFG_EN
                    state_d    = ST_DIVCFG;
                    start      = 1'b1;
                    pulse_only = 1'b1;
                    mnrst_d    = 1'b0;
                    nbits_d    = 5'd31;
                    mosi_d     = {DIVCFG_CMD, DIV_COEF};
                    phase_d    = 2'd0;
`else
                    state_d = ST_WHOAMI;
                    start   = 1'b1;
                    nbits_d = 5'd15;
                    mosi_d  = WHOAMI_CMD;
`endif
                end
`ifdef SPI_DIVCFG_EN
                ST_DIVCFG: begin
                    phase_d = phase_q + 1'b1;
                    if (phase_q == 2'd1) begin
                        mnrst_d = 1'b1;
                        nbits_d = 5'd0;
                        mosi_d  = 32'h0;
                    end else if (phase_q == 2'd2) begin
                        state_d = ST_WHOAMI;
                        start   = 1'b1;
                        nbits_d = 5'd15;
                        mosi_d  = WHOAMI_CMD;
                    end
                end
`endif
                ST_WHOAMI: if (hs_done) state_d = ST_CHK_ID;
                ST_CHK_ID: begin
                    if (hs_rdata[7:0] === WHOAMI_VAL) begin
                        id_ok_d = 1'b1;
                        state_d = ST_WR_CTRL1;
                        start   = 1'b1;
                        nbits_d = 5'd15;
                        mosi_d  = {16'h0, REG_CTRL1, CTRL1_VAL};
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERROR;
                    end
                end
                // saturate the period counter so the first set starts at once
                ST_WR_CTRL1: if (hs_done) begin
                    state_d = ST_WAIT_PERIOD;
                    per_d   = PER_LAST;
                end
                ST_WAIT_PERIOD: begin
                    if (!enable)                state_d   = ST_IDLE_HOLD;
                    else if (per_q == PER_LAST) begin_set = 1'b1;
                end
                ST_RD_X: if (hs_done) begin
                    shx_d   = axis_val;
                    state_d = ST_RD_Y;
                    start   = 1'b1;
                    mosi_d  = {8'h0, axis_rd_cmd(2'd1), 16'h0};
                end
                ST_RD_Y: if (hs_done) begin
                    shy_d   = axis_val;
                    state_d = ST_RD_Z;
                    start   = 1'b1;
                    mosi_d  = {8'h0, axis_rd_cmd(2'd2), 16'h0};
                end
                ST_RD_Z: if (hs_done) begin
                    acc_x_d = shx_q;
                    acc_y_d = shy_q;
                    acc_z_d = axis_val;
                    state_d = ST_PUBLISH;
                end
                ST_PUBLISH: begin
                    if (enable && per_q == PER_LAST) begin_set = 1'b1;
                    else                             state_d   = ST_WAIT_PERIOD;
                end
                ST_IDLE_HOLD: if (enable) state_d = ST_WAIT_PERIOD;
                default: ;
            endcase
        end
        if (begin_set) begin
            state_d = ST_RD_X;
            start   = 1'b1;
            nbits_d = 5'd23;
            mosi_d  = {8'h0, axis_rd_cmd(2'd0), 16'h0};
            per_d   = '0;
        end
        valid_d = (state_d == ST_PUBLISH);
        busy_d  = (state_d != ST_IDLE_OFF) && (state_d != ST_ERROR);
    end

    always_ff @(posedge clk_in) begin
        if (!nrst) begin
            state_q <= ST_IDLE_OFF;
            nbits_q <= '0;
            mosi_q  <= '0;
            acc_x_q <= '0;
            acc_y_q <= '0;
            acc_z_q <= '0;
            shx_q   <= '0;
            shy_q   <= '0;
            valid_q <= 1'b0;
            id_ok_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            per_q   <= '0;
`ifdef SPI_DIVCFG_EN
            mnrst_q <= 1'b1;
            phase_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            nbits_q <= nbits_d;
            mosi_q  <= mosi_d;
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            acc_z_q <= acc_z_d;
            shx_q   <= shx_d;
            shy_q   <= shy_d;
            valid_q <= valid_d;
            id_ok_q <= id_ok_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            per_q   <= per_d;
`ifdef SPI_DIVCFG_EN
            mnrst_q <= mnrst_d;
            phase_q <= phase_d;
`endif
        end
    end

`ifdef SPI_DIVCFG_EN
    logic unused_miso_hi;
    assign unused_miso_hi      = ^spi.spi_miso_data[31:16];
    assign spi.spi_master_nrst = mnrst_q;
`else
    // the divider coefficient only matters when the config step is built in
    logic unused_miso_hi;
    assign unused_miso_hi      = ^{spi.spi_miso_data[31:16], DIV_COEF};
    assign spi.spi_master_nrst = 1'b1;
`endif

    assign spi.spi_nbits     = nbits_q;
    assign spi.spi_mosi_data = mosi_q;
    assign acc_x             = acc_x_q;
    assign acc_y             = acc_y_q;
    assign acc_z             = acc_z_q;
    assign sample_valid      = valid_q;
    assign id_ok             = id_ok_q;
    assign err               = err_q;
    assign busy              = busy_q;
endmodule
